// File: rtl/data_package_src.sv
// ---------------------------------------------------------------------------
// data_package_src
//
// Stages upstream bytes in a small FIFO, grouped into packets (in_last marks
// the final byte). On a start request, every complete packet held in the FIFO
// is sent downstream back-to-back, one byte per cycle. After the last byte of
// the session, done pulses for one cycle.
//
// Oversize packets are caught here. If the FIFO fills without holding a single
// complete packet, nothing could ever be sent, so the block would deadlock.
// In that case the FIFO is flushed and len_err is set. The remaining bytes of
// the offending packet are then swallowed, up to and including its last byte.
//
// Ports
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_vld    : upstream byte valid
//   in_rdy    : staging FIFO can accept (registered !full)
//   in_data   : upstream byte
//   in_type   : packet type (1 high, 0 low), sampled on the first byte
//   in_last   : final byte of a packet
//   start     : single-cycle request to open a transmit session
//   wen       : downstream write enable, high on every byte-carrying cycle
//   pkg_in    : downstream byte
//   pkg_type  : downstream packet type, constant across a packet
//               (named pkg_type because "type" is a reserved word)
//   sent_num  : bytes sent in the current/last session (wraps)
//   done      : one-cycle pulse at session end
//   len_err   : sticky packet-length violation flag
// ---------------------------------------------------------------------------
module data_package_src #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_type,
  input  logic                  in_last,
  input  logic                  start,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] pkg_in,
  output logic                  pkg_type,
  output logic [ADDR_WIDTH-1:0] sent_num,
  output logic                  done,
  output logic                  len_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;

  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] NUM_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] NUM_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);
  localparam logic [3:0]            LEN_ZERO = 4'd0;
  localparam logic [3:0]            LEN_MIN  = 4'd4;
  localparam logic [3:0]            LEN_MAX  = 4'd10;
  localparam logic [3:0]            LEN_SAT  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Packet-length counter increment that sticks at its maximum.
  function automatic logic [3:0] len_sat_inc(input logic [3:0] len);
    if (len == LEN_SAT) begin
      return LEN_SAT;
    end else begin
      return len + 4'd1;
    end
  endfunction

  // Staging storage: entry = {last, type, data}
  logic [ENT_W-1:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [CNT_W-1:0]      pkt_cnt_r;
  logic [CNT_W-1:0]      pkt_cnt_nxt_s;
  logic                  in_rdy_r;
  logic                  discard_r;
  logic [3:0]            in_len_r;
  logic [3:0]            len_inc_s;
  logic                  in_type_r;
  logic                  len_err_r;

  state_t                state_r;
  state_t                state_nxt_s;

  logic                  wen_r;
  logic [DATA_WIDTH-1:0] pkg_in_r;
  logic                  type_r;
  logic [ADDR_WIDTH-1:0] sent_num_r;
  logic                  done_r;
  logic                  out_first_r;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic                  push_last_s;
  logic                  pop_last_s;
  logic                  session_start_s;
  logic                  wr_type_s;
  logic [ENT_W-1:0]      wr_entry_s;
  logic [ENT_W-1:0]      rd_entry_s;
  logic                  rd_last_s;
  logic                  rd_type_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Handshake and FIFO access strobes.
  always_comb begin
    accept_s    = in_vld && in_rdy_r;
    // While discarding an oversize tail, bytes are accepted but not stored.
    push_s      = accept_s && !discard_r;
    // Only the SEND state pops, and it is only entered with a complete packet staged.
    pop_s       = (state_r == ST_SEND);
    // A full FIFO with no complete packet can never drain.
    flush_s     = (count_r == DEPTH_C) && (pkt_cnt_r == CNT_ZERO);
    wr_type_s   = (in_len_r == LEN_ZERO) ? in_type : in_type_r;
    wr_entry_s  = {in_last, wr_type_s, in_data};
    rd_entry_s  = mem_r[rd_ptr_r];
    rd_last_s   = rd_entry_s[ENT_W-1];
    rd_type_s   = rd_entry_s[ENT_W-2];
    rd_data_s   = rd_entry_s[DATA_WIDTH-1:0];
    push_last_s = push_s && in_last;
    pop_last_s  = pop_s && rd_last_s;
    len_inc_s   = len_sat_inc(in_len_r);
    session_start_s = (state_r == ST_IDLE) && start && (pkt_cnt_r != CNT_ZERO);
  end

  // Next FIFO occupancy and complete-packet count.
  always_comb begin
    count_nxt_s   = count_r;
    pkt_cnt_nxt_s = pkt_cnt_r;
    if (flush_s) begin
      count_nxt_s   = CNT_ZERO;
      pkt_cnt_nxt_s = CNT_ZERO;
    end else begin
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
      if (push_last_s && !pop_last_s) begin
        pkt_cnt_nxt_s = pkt_cnt_r + CNT_ONE;
      end else if (pop_last_s && !push_last_s) begin
        pkt_cnt_nxt_s = pkt_cnt_r - CNT_ONE;
      end else begin
        pkt_cnt_nxt_s = pkt_cnt_r;
      end
    end
  end

  // FIFO storage write port (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // FIFO control, input packet tracking, and length-error detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      pkt_cnt_r <= CNT_ZERO;
      in_rdy_r  <= 1'b1;
      discard_r <= 1'b0;
      in_len_r  <= LEN_ZERO;
      in_type_r <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      pkt_cnt_r <= pkt_cnt_nxt_s;
      // Registered full flag, so in_rdy never depends combinationally on pop.
      in_rdy_r  <= (count_nxt_s != DEPTH_C);
      if (flush_s) begin
        wr_ptr_r  <= PTR_ZERO;
        rd_ptr_r  <= PTR_ZERO;
        discard_r <= 1'b1;
        in_len_r  <= LEN_ZERO;
        len_err_r <= 1'b1;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (accept_s && discard_r && in_last) begin
          discard_r <= 1'b0;
        end
        if (push_s) begin
          if (in_len_r == LEN_ZERO) begin
            in_type_r <= in_type;
          end
          if (in_last) begin
            in_len_r <= LEN_ZERO;
            if ((len_inc_s < LEN_MIN) || (len_inc_s > LEN_MAX)) begin
              len_err_r <= 1'b1;
            end
          end else begin
            in_len_r <= len_inc_s;
          end
        end
      end
    end
  end

  // Session FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Session FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (session_start_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        // A newly completed incoming packet keeps the session running.
        if (pop_last_s && (pkt_cnt_nxt_s == CNT_ZERO)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered downstream outputs. A byte popped in one cycle appears in the next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_r       <= 1'b0;
      pkg_in_r    <= DATA_ZERO;
      type_r      <= 1'b0;
      sent_num_r  <= NUM_ZERO;
      done_r      <= 1'b0;
      out_first_r <= 1'b1;
    end else begin
      wen_r  <= pop_s;
      done_r <= (state_r == ST_DONE);
      if (pop_s) begin
        pkg_in_r    <= rd_data_s;
        sent_num_r  <= sent_num_r + NUM_ONE;
        out_first_r <= rd_last_s;
        // Type is taken from a packet's first entry and held through its last byte.
        if (out_first_r) begin
          type_r <= rd_type_s;
        end
      end else if (session_start_s) begin
        sent_num_r <= NUM_ZERO;
      end
    end
  end

  assign in_rdy   = in_rdy_r;
  assign wen      = wen_r;
  assign pkg_in   = pkg_in_r;
  assign pkg_type = type_r;
  assign sent_num = sent_num_r;
  assign done     = done_r;
  assign len_err  = len_err_r;

endmodule

// File: tb/tb_data_package_src.sv
module tb_data_package_src;

  logic       clk;
  logic       rst_n;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       in_type;
  logic       in_last;
  logic       start;
  logic       wen;
  logic [7:0] pkg_in;
  logic       pkg_type;
  logic [6:0] sent_num;
  logic       done;
  logic       len_err;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] exp_d [0:15];
  logic       exp_t [0:15];

  data_package_src #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(7),
    .FIFO_DEPTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_type  (in_type),
    .in_last  (in_last),
    .start    (start),
    .wen      (wen),
    .pkg_in   (pkg_in),
    .pkg_type (pkg_type),
    .sent_num (sent_num),
    .done     (done),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic t, input logic l);
    int w;
    in_data = d;
    in_type = t;
    in_last = l;
    in_vld  = 1'b1;
    w = 0;
    while (!in_rdy && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      n_asrt++;
      n_fail++;
      $display("FAIL push_timeout: observed in_rdy=0 for 50 cycles expected in_rdy=1");
    end
    tick();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Pulses start and checks n contiguous bytes against exp_d/exp_t, then done.
  task automatic run_session(input string tag, input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_wen_lat", tag), 32'(wen), 32'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_wen%0d", tag, i), 32'(wen), 32'd1);
      check($sformatf("%s_data%0d", tag, i), 32'(pkg_in), 32'(exp_d[i]));
      check($sformatf("%s_type%0d", tag, i), 32'(pkg_type), 32'(exp_t[i]));
      check($sformatf("%s_nodone%0d", tag, i), 32'(done), 32'd0);
    end
    tick();
    check($sformatf("%s_wen_end", tag), 32'(wen), 32'd0);
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_sent_num", tag), 32'(sent_num), 32'(n));
    tick();
    check($sformatf("%s_done_drop", tag), 32'(done), 32'd0);
    check($sformatf("%s_sent_hold", tag), 32'(sent_num), 32'(n));
  endtask

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = 8'h00;
    in_type = 1'b0;
    in_last = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_pkg_in", 32'(pkg_in), 32'd0);
    check("rst_type", 32'(pkg_type), 32'd0);
    check("rst_sent_num", 32'(sent_num), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);

    // One low packet of 5 bytes
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h11 + 8'(i), 1'b0, (i == 4));
      exp_d[i] = 8'h11 + 8'(i);
      exp_t[i] = 1'b0;
    end
    check("p5_len_err", 32'(len_err), 32'd0);
    run_session("p5", 5);

    // Start with empty FIFO is ignored; sent_num keeps its last value
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("empty_wen%0d", i), 32'(wen), 32'd0);
      check($sformatf("empty_done%0d", i), 32'(done), 32'd0);
    end
    check("empty_sent_num", 32'(sent_num), 32'd5);

    // High 4-byte packet then low 6-byte packet; type only sampled on first byte
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hA0 + 8'(i), (i == 0), (i == 3));
      exp_d[i] = 8'hA0 + 8'(i);
      exp_t[i] = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h30 + 8'(i), (i != 0), (i == 5));
      exp_d[4+i] = 8'h30 + 8'(i);
      exp_t[4+i] = 1'b0;
    end
    check("p10_len_err", 32'(len_err), 32'd0);
    run_session("p10", 10);

    // Short 3-byte packet: len_err sets but packet still goes out
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h51 + 8'(i), 1'b1, (i == 2));
      exp_d[i] = 8'h51 + 8'(i);
      exp_t[i] = 1'b1;
    end
    check("short_len_err", 32'(len_err), 32'd1);
    run_session("short", 3);
    check("short_len_err_sticky", 32'(len_err), 32'd1);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst2_len_err", 32'(len_err), 32'd0);

    // 16 bytes without last: flush, len_err, tail discarded, then good packet
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    end
    check("ovf_full_rdy", 32'(in_rdy), 32'd0);
    check("ovf_pre_len_err", 32'(len_err), 32'd0);
    tick();
    check("ovf_rdy_back", 32'(in_rdy), 32'd1);
    check("ovf_len_err", 32'(len_err), 32'd1);
    push_byte(8'h70, 1'b0, 1'b0);
    push_byte(8'h71, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h81 + 8'(i), (i == 0), (i == 3));
      exp_d[i] = 8'h81 + 8'(i);
      exp_t[i] = 1'b1;
    end
    run_session("ovf_pkt", 4);

    // Reset during the third byte of a session
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h91 + 8'(i), 1'b0, (i == 4));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_wen3", 32'(wen), 32'd1);
    check("mid_data3", 32'(pkg_in), 32'h93);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_wen_drop", 32'(wen), 32'd0);
    check("mid_sent_num", 32'(sent_num), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_in_rdy", 32'(in_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_post_done%0d", i), 32'(done), 32'd0);
      check($sformatf("mid_post_wen%0d", i), 32'(wen), 32'd0);
    end
    // Staged data was lost, so a start now finds nothing to send
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_lost_wen%0d", i), 32'(wen), 32'd0);
      check($sformatf("mid_lost_done%0d", i), 32'(done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/data_package_src.md
DATA_PACKAGE_SRC -- requirements
Module: data_package_src

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, SHALL set byte width of in_data and pkg_in.
- REQ-002: Parameter ADDR_WIDTH, default 7, SHALL set width of sent_num.
- REQ-003: Parameter FIFO_DEPTH, default 16, SHALL set the number of internal staging entries (power of two, at least 16).
- REQ-004: The block SHALL use one clock; reset is synchronous and active-low.
- REQ-005: clk, input, 1, sole clock; all logic on rising edge.
- REQ-006: rst_n, input, 1, synchronous active-low reset.
- REQ-007: in_vld, input, 1, upstream byte valid.
- REQ-008: in_rdy, output, 1, staging FIFO can accept; equals !full.
- REQ-009: in_data, input, DATA_WIDTH, upstream byte.
- REQ-010: in_type, input, 1, packet type (1 high, 0 low); sampled on first byte of each packet.
- REQ-011: in_last, input, 1, marks final byte of a packet.
- REQ-012: start, input, 1, single-cycle request to open a transmit session.
- REQ-013: wen, output, 1, downstream write enable; high exactly on cycles carrying a byte.
- REQ-014: pkg_in, output, DATA_WIDTH, downstream byte.
- REQ-015: type, output, 1, downstream packet type, constant for a whole packet.
- REQ-016: sent_num, output, ADDR_WIDTH, bytes sent in current/last session.
- REQ-017: done, output, 1, one-cycle pulse at session end.
- REQ-018: len_err, output, 1, sticky packet-length violation flag.

Function
- REQ-019: A byte SHALL be accepted on cycles with in_vld && in_rdy and stored as {in_last, packet type, in_data}.
- REQ-020: pkt_cnt SHALL count complete packets in the FIFO: +1 on accepting a last byte, -1 on popping a last byte, unchanged when both occur.
- REQ-021: Input length counter SHALL count bytes of the packet being accepted (saturating at 15) and clear after a last byte.
- REQ-022: On accepting a last byte with length <4 or >10, len_err SHALL set; the packet is still transmitted.
- REQ-023: States SHALL be IDLE, SEND, DONE.
- REQ-024: IDLE: wen=0, done=0; start && pkt_cnt>0 -> SEND and sent_num cleared to 0; start with pkt_cnt==0 ignored.
- REQ-025: SEND: one FIFO entry popped per cycle with no gaps; outputs registered, so a byte popped in cycle t appears with wen=1 in cycle t+1.
- REQ-026: type SHALL be latched from the first entry of each packet and held until its last byte.
- REQ-027: sent_num SHALL increment per byte output, wrapping modulo 2**ADDR_WIDTH.
- REQ-028: On popping a last byte: if pkt_cnt after update >0, continue with next packet back-to-back (wen stays high); else -> DONE.
- REQ-029: DONE: one cycle, wen=0, done=1; then -> IDLE; sent_num held until next session start.
- REQ-030: start during SEND or DONE SHALL be ignored.
- REQ-031: FIFO full with pkt_cnt==0 (oversize packet, deadlock) SHALL flush the FIFO in one cycle, set len_err, and discard remaining bytes of that packet up to and including its last byte.
- REQ-032: Simultaneous push and pop SHALL be allowed, including when full (pop frees the slot in the same cycle only if in_rdy was computed from registered full; in_rdy shall not combinationally depend on pop).

Reset
- REQ-033: rst_n=0 at a rising edge SHALL set state IDLE, empty FIFO, pkt_cnt=0, wen=0, pkg_in=0, type=0, sent_num=0, done=0, len_err=0, in_rdy=1 next cycle.
- REQ-034: Reset mid-SEND SHALL drop wen the following cycle with no done pulse; staged data is lost.

Verification
- REQ-035: Push one low packet of 5 bytes 0x11..0x15, pulse start -> wen high 5 consecutive cycles, pkg_in 0x11..0x15, type=0, then done=1 with sent_num=5.
- REQ-036: Push high packet (4 bytes) then low packet (6 bytes), start -> 10 contiguous wen cycles, type 1 for first 4 and 0 for last 6, sent_num=10.
- REQ-037: Start with empty FIFO -> no wen, no done; state stays IDLE.
- REQ-038: Push 3-byte packet -> len_err=1 after last accepted; packet still sent with sent_num=3; len_err stays 1 until reset.
- REQ-039: Push 16 bytes without in_last -> flush, len_err=1, in_rdy returns 1, subsequent valid 4-byte packet transmits correctly.
- REQ-040: Assert rst_n=0 during third byte of a session -> wen=0 next cycle, done never pulses, sent_num=0.
